// File: rtl/y86_bus_pkg.sv
// Shared constants for the y86 memory-bus responder: I/O page layout, STATUS bit positions, decode classes.
package y86_bus_pkg;

    localparam logic [31:0] IO_BASE    = 32'hFFFF_FF00;
    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;
    localparam logic [31:0] CYCLES_OFS = 32'h0000_0008;

    localparam int STAT_CNT_MSB  = 4;
    localparam int STAT_FULL_BIT = 8;
    localparam int STAT_ERR_BIT  = 9;
    localparam int STAT_OVF_BIT  = 10;

    typedef enum logic [2:0] {
        RAM,
        IO_TX,
        IO_STAT,
        IO_CYC,
        UNMAPPED
    } dec_e;

endpackage

// File: rtl/y86_tx_fifo.sv
// Synchronous FIFO: push lands at the clock edge, head is visible the cycle after (no bypass).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module y86_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    logic [WIDTH-1:0] slot_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign pop_dat = slot_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                slot_q[wr_ptr_q] <= push_dat;
                wr_ptr_q         <= wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/y86_bus_responder.sv
// y86 memory-bus responder: byte RAM plus I/O page (console TX FIFO, STATUS, CYCLES); zero-latency reads, writes at the edge.
// No bus backpressure; the TX FIFO drains on tx_valid && tx_ready and drops (flagging ovf) when full without a pop.
module y86_bus_responder
    import y86_bus_pkg::*;
#(
    parameter int    DEPTH      = 4096,
    parameter string INIT_FILE  = "",
    parameter int    FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_A,
    input  logic        bus_RE,
    input  logic        bus_WE,
    input  logic [31:0] bus_out,
    output logic [31:0] bus_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    mem_q [DEPTH];
    dec_e          dec;
    logic [31:0]   lane_addr [4];
    logic [3:0]    lane_ok;
    logic [31:0]   ram_rdata;
    logic [31:0]   status;
    logic [31:0]   cyc_q, cyc_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic          acc_err;
    logic          tx_push;
    logic          tx_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] = 8'h00;
        end
    end

    always_comb begin
        dec = UNMAPPED;
        if (bus_A < 32'(DEPTH))                 dec = RAM;
        else if (bus_A == IO_BASE + TXDATA_OFS) dec = IO_TX;
        else if (bus_A == IO_BASE + STATUS_OFS) dec = IO_STAT;
        else if (bus_A == IO_BASE + CYCLES_OFS) dec = IO_CYC;
    end

    // An access near the top of RAM may straddle DEPTH; each lane is qualified on its own.
    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = bus_A + 32'(i);
            lane_ok[i]   = (dec == RAM) && (lane_addr[i] < 32'(DEPTH));
            if (lane_ok[i]) ram_rdata[8*i +: 8] = mem_q[lane_addr[i][AW-1:0]];
        end
    end

    // Gating on rst keeps a write that coincides with reset assertion out of the RAM.
    always @(posedge clk) begin
        if (rst && bus_WE) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_ok[i]) mem_q[lane_addr[i][AW-1:0]] <= bus_out[8*i +: 8];
            end
        end
    end

    always_comb begin
        status                      = '0;
        status[STAT_CNT_MSB:0]      = 5'(fifo_count);
        status[STAT_FULL_BIT]       = fifo_full;
        status[STAT_ERR_BIT]        = err_q;
        status[STAT_OVF_BIT]        = ovf_q;
    end

    always_comb begin
        bus_in = '0;
        if (bus_RE) begin
            case (dec)
                RAM:     bus_in = ram_rdata;
                IO_STAT: bus_in = status;
                IO_CYC:  bus_in = cyc_q;
                default: bus_in = '0;
            endcase
        end
    end

    assign tx_push = bus_WE && (dec == IO_TX);
    assign tx_pop  = tx_valid && tx_ready;
    assign acc_err = ((bus_RE || bus_WE) &&
                      ((dec == UNMAPPED) || ((dec == RAM) && (lane_ok != 4'hF))))
                     || (bus_RE && bus_WE);

    assign err_d = err_q | acc_err;
    assign ovf_d = ovf_q | (tx_push && fifo_full && !tx_pop);
    assign cyc_d = cyc_q + 32'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cyc_q <= cyc_d;
            err_q <= err_d;
            ovf_q <= ovf_d;
        end
    end

    y86_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_dat (bus_out[7:0]),
        .pop      (tx_pop),
        .pop_dat  (tx_data),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tx_valid = !fifo_empty;
    assign err      = err_q;

endmodule

// File: tb/tb_y86_bus_responder.sv
// Directed bench for y86_bus_responder: expected reads and TX bytes are queued at issue time and checked by a monitor.
module tb_y86_bus_responder;

    localparam logic [31:0] A_TX = 32'hFFFF_FF00;
    localparam logic [31:0] A_ST = 32'hFFFF_FF04;
    localparam logic [31:0] A_CY = 32'hFFFF_FF08;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bus_A;
    logic        bus_RE;
    logic        bus_WE;
    logic [31:0] bus_out;
    logic [31:0] bus_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_exp_q [$];
    string       rd_nm_q  [$];
    logic [7:0]  tx_exp_q [$];

    y86_bus_responder dut (
        .clk      (clk),
        .rst      (rst),
        .bus_A    (bus_A),
        .bus_RE   (bus_RE),
        .bus_WE   (bus_WE),
        .bus_out  (bus_out),
        .bus_in   (bus_in),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_A   = a;
        bus_out = d;
        bus_WE  = 1'b1;
        cyc();
        bus_WE  = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus_A  = a;
        bus_RE = 1'b1;
        rd_exp_q.push_back(exp);
        rd_nm_q.push_back(nm);
        cyc();
        bus_RE = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus_RE) begin
            checks++;
            if (rd_exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h expected no read", bus_in);
            end else begin
                checks--;
                chk(rd_nm_q.pop_front(), bus_in, rd_exp_q.pop_front());
            end
        end
        if (tx_valid && tx_ready) begin
            checks++;
            if (tx_exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
            end else begin
                checks--;
                chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; bus_A = '0; bus_RE = 1'b0; bus_WE = 1'b0; bus_out = '0; tx_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_err",      {31'h0, err},      32'h0);
        chk("rst_tx_data",  {24'h0, tx_data},  32'h0);
        rst = 1'b1;
        bus_read(A_CY, 32'h0, "rst_cycles");
        bus_read(A_ST, 32'h0, "rst_status");
        chk("idle_bus_in", bus_in, 32'h0);

        // unaligned read
        bus_write(32'h0, 32'h1312_1110);
        bus_write(32'h4, 32'h1716_1514);
        bus_read(32'h3, 32'h1615_1413, "unaligned");
        chk("unaligned_err", {31'h0, err}, 32'h0);

        // write then read back
        bus_write(32'h101, 32'hDEAD_BEEF);
        bus_read(32'h100, 32'hADBE_EF00, "wr_rd_100");
        bus_read(32'h101, 32'hDEAD_BEEF, "wr_rd_101");
        chk("wr_rd_err", {31'h0, err}, 32'h0);

        // top-of-RAM straddle
        bus_write(32'hFFC, 32'hBBAA_0000);
        chk("top_wr_err", {31'h0, err}, 32'h0);
        bus_read(32'hFFE, 32'h0000_BBAA, "boundary");
        chk("boundary_err", {31'h0, err}, 32'h1);
        bus_read(32'h100, 32'hADBE_EF00, "after_boundary");
        chk("err_sticky", {31'h0, err}, 32'h1);
        bus_read(A_ST, 32'h0000_0200, "status_err");

        // FIFO fill: first push must not be visible in its own cycle
        bus_A = A_TX; bus_out = 32'h30; bus_WE = 1'b1;
        tx_exp_q.push_back(8'h30);
        #1;
        chk("no_bypass", {31'h0, tx_valid}, 32'h0);
        cyc();
        bus_WE = 1'b0;
        chk("valid_after_push", {31'h0, tx_valid}, 32'h1);
        for (int i = 1; i < 9; i++) begin
            bus_write(A_TX, 32'h30 + 32'(i));
            if (i < 8) tx_exp_q.push_back(8'(8'h30 + i));
        end
        chk("head_hold", {24'h0, tx_data}, 32'h30);
        bus_read(A_ST, 32'h0000_0708, "status_full_ovf");
        tx_ready = 1'b1;
        repeat (7) cyc();
        chk("valid_before_last", {31'h0, tx_valid}, 32'h1);
        cyc();
        chk("valid_after_drain", {31'h0, tx_valid}, 32'h0);
        chk("drain_all", 32'(tx_exp_q.size()), 32'h0);
        tx_ready = 1'b0;

        // reset: counter restarts, RAM survives
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        bus_read(A_CY, 32'h0, "cycles_0");
        bus_read(A_CY, 32'h1, "cycles_1");
        bus_read(A_ST, 32'h0, "status_after_rst");
        bus_read(32'h3, 32'h1615_1413, "ram_retained");
        bus_read(32'h101, 32'hDEAD_BEEF, "ram_retained_101");

        // both strobes: read sees old data, write lands, err set
        bus_A = 32'h10; bus_out = 32'h1122_3344; bus_RE = 1'b1; bus_WE = 1'b1;
        rd_exp_q.push_back(32'h0);
        rd_nm_q.push_back("both_old");
        cyc();
        bus_RE = 1'b0; bus_WE = 1'b0;
        chk("both_err", {31'h0, err}, 32'h1);
        bus_read(32'h10, 32'h1122_3344, "both_new");

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            bus_write(A_TX, 32'h50 + 32'(i));
            tx_exp_q.push_back(8'(8'h50 + i));
        end
        bus_A = A_TX; bus_out = 32'h41; bus_WE = 1'b1; tx_ready = 1'b1;
        tx_exp_q.push_back(8'h41);
        cyc();
        bus_WE = 1'b0; tx_ready = 1'b0;
        bus_read(A_ST, 32'h0000_0308, "status_push_pop");

        // reset mid-drain
        tx_ready = 1'b1;
        repeat (3) cyc();
        #1;
        rst = 1'b0;
        #1;
        chk("async_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("async_tx_data",  {24'h0, tx_data},  32'h0);
        tx_exp_q.delete();
        tx_ready = 1'b0;
        bus_write(32'h200, 32'h1234_5678);
        cyc();
        rst = 1'b1;
        bus_read(32'h200, 32'h0, "wr_in_reset");
        bus_read(A_ST, 32'h0, "status_mid_rst");
        bus_read(A_CY, 32'h2, "cycles_2");
        bus_read(32'h8000, 32'h0, "unmapped_rd");
        chk("unmapped_err", {31'h0, err}, 32'h1);
        bus_read(A_TX, 32'h0, "txdata_rd");

        cyc();
        cyc();
        chk("rd_queue_empty", 32'(rd_exp_q.size()), 32'h0);
        chk("tx_queue_empty", 32'(tx_exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
